poly8_arbiter: RTL and testbench

- Round-robin arbiter and call sequencer that shares one poly8 HLS component instance among NREQ requesters.
- Accepts per-requester call requests (idx), issues them one at a time on the component's call interface, captures returndata, and returns it to the winning requester.
- Sits between requester pipelines and the single poly8 instance; one call outstanding at a time.

---
 rtl/poly8_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/poly8_arbiter.sv | 131 +++++++++++++
 tb/tb_poly8_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly8_ctrl_pkg.sv
// Shared definitions for poly8 call scheduling: FSM states, default data width and
// the grant-index width helper.
package poly8_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    localparam int unsigned DATA_W_DEFAULT = 32;

    // Width of a binary requester index; never zero so a single requester still works.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr (mod NREQ) wins,
// reported both one-hot and as a binary index.
module rr_arbiter
    import poly8_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW = grant_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    always_comb begin
        logic [IW-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IW'((32'(ptr) + off) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/poly8_arbiter.sv
// Shares one poly8 component among NREQ requesters: round-robin accept, issue one call,
// capture the result and hand it back to the requester that asked for it.
module poly8_arbiter
    import poly8_ctrl_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_idx,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   k_start,
    input  logic                   k_busy,
    output logic [DATA_W-1:0]      k_idx,
    input  logic                   k_done,
    output logic                   k_stall,
    input  logic [DATA_W-1:0]      k_returndata,
    output logic [CNT_W-1:0]       calls_done,
    output logic                   idle
);

    localparam int unsigned IW = grant_w(NREQ);

    state_e              state_q;
    logic [IW-1:0]       grant_q;
    logic [IW-1:0]       rr_ptr_q;
    logic [DATA_W-1:0]   idx_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [CNT_W-1:0]    calls_done_q;
    logic                k_start_q;
    logic                k_stall_q;
    logic                idle_q;
    logic [NREQ-1:0]     rsp_valid_q;

    logic [NREQ-1:0]     arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic [NREQ-1:0]     grant_oh;
    logic [DATA_W-1:0]   idx_arr [NREQ];

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx_arr[i] = req_idx[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

    // Only the accept handshake is combinational; everything toward poly8 is registered.
    assign req_ready  = (state_q == StIdle) ? arb_gnt : '0;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign k_start    = k_start_q;
    assign k_idx      = idx_q;
    assign k_stall    = k_stall_q;
    assign calls_done = calls_done_q;
    assign idle       = idle_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_ptr_q     <= IW'(NREQ - 1);
            idx_q        <= '0;
            rsp_data_q   <= '0;
            calls_done_q <= '0;
            k_start_q    <= 1'b0;
            k_stall_q    <= 1'b1;
            idle_q       <= 1'b1;
            rsp_valid_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        idx_q     <= idx_arr[arb_idx];
                        grant_q   <= arb_idx;
                        k_start_q <= 1'b1;
                        idle_q    <= 1'b0;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    if (!k_busy) begin
                        k_start_q <= 1'b0;
                        k_stall_q <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (k_done) begin
                        rsp_data_q  <= k_returndata;
                        k_stall_q   <= 1'b1;
                        rsp_valid_q <= grant_oh;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    // Completed requester drops to lowest priority for the next pick.
                    if (|(rsp_ready & grant_oh)) begin
                        rr_ptr_q     <= grant_q;
                        calls_done_q <= calls_done_q + 1'b1;
                        rsp_valid_q  <= '0;
                        idle_q       <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_poly8_arbiter.sv
// Randomized and directed bench for poly8_arbiter with a transaction-level reference
// model and a behavioural poly8 component responder.
module tb_poly8_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic                   clock = 1'b0;
    logic                   resetn = 1'b0;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_idx;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]      rsp_data;
    logic                   k_start;
    logic                   k_busy;
    logic [DATA_W-1:0]      k_idx;
    logic                   k_done;
    logic                   k_stall;
    logic [DATA_W-1:0]      k_returndata;
    logic [CNT_W-1:0]       calls_done;
    logic                   idle;

    poly8_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_idx      (req_idx),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .k_start      (k_start),
        .k_busy       (k_busy),
        .k_idx        (k_idx),
        .k_done       (k_done),
        .k_stall      (k_stall),
        .k_returndata (k_returndata),
        .calls_done   (calls_done),
        .idle         (idle)
    );

    always #5 clock = ~clock;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference: 0 free, 1 call pending issue, 2 awaiting result, 3 result offered.
    int                ref_stage;
    int unsigned       ref_last;
    int unsigned       ref_grant;
    logic [DATA_W-1:0] ref_idx;
    logic [CNT_W-1:0]  ref_count;

    logic              comp_pending;
    int unsigned       comp_cnt;
    logic [DATA_W-1:0] comp_res;
    int                comp_lat;
    int unsigned       comp_calls;

    logic              rq_v   [NREQ];
    logic [DATA_W-1:0] rq_idx [NREQ];
    bit                hold_req, rand_req, rand_busy, rand_rsp;
    int unsigned       busy_hold, rsp_hold, kstart_cycles, cyc;
    int                rsp_first;
    int unsigned       grant_log [$];

    logic              s_kstart, s_kbusy, s_kdone, s_kstall;
    logic [DATA_W-1:0] s_kidx;
    logic [NREQ-1:0]   s_rsp_ready;
    int                s_win;

    function automatic logic [DATA_W-1:0] poly(input logic [DATA_W-1:0] x);
        return x * x * x + 32'd3 * x * x + 32'd5 * x + 32'd8;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        logic [NREQ-1:0] gmask;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                = rq_v[i];
            req_idx[i*DATA_W +: DATA_W] = rq_idx[i];
        end
        if (ref_stage == 1 && busy_hold > 0) begin
            k_busy = 1'b1;
            busy_hold--;
        end else begin
            k_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        k_done       = comp_pending && (comp_cnt == 0);
        k_returndata = k_done ? comp_res : $urandom();
        if (comp_pending && comp_cnt > 0) comp_cnt--;
        gmask            = '0;
        gmask[ref_grant] = 1'b1;
        rsp_ready        = rand_rsp ? NREQ'($urandom()) : '1;
        if (ref_stage == 3 && rsp_hold > 0) begin
            rsp_ready = rsp_ready & ~gmask;
            rsp_hold--;
        end
    endtask

    task automatic check_and_sample();
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rv;
        s_win = -1;
        if (ref_stage == 0) begin
            for (int unsigned off = 1; off <= NREQ; off++) begin
                int unsigned c;
                c = (ref_last + off) % NREQ;
                if (s_win < 0 && rq_v[c]) s_win = int'(c);
            end
        end
        exp_ready = '0;
        if (s_win >= 0) exp_ready[s_win] = 1'b1;
        exp_rv = '0;
        if (ref_stage == 3) exp_rv[ref_grant] = 1'b1;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("idle", idle, ref_stage == 0);
        check_eq("k_start", k_start, ref_stage == 1);
        if (ref_stage == 1) check_eq("k_idx", k_idx, ref_idx);
        check_eq("k_stall", k_stall, ref_stage != 2);
        check_eq("rsp_valid", rsp_valid, exp_rv);
        if (ref_stage == 3) check_eq("rsp_data", rsp_data, poly(ref_idx));
        check_eq("calls_done", calls_done, ref_count);
        if (k_start === 1'b1) kstart_cycles++;
        if (rsp_valid !== '0 && rsp_first < 0) rsp_first = int'(cyc);
        s_kstart    = k_start;
        s_kbusy     = k_busy;
        s_kdone     = k_done;
        s_kstall    = k_stall;
        s_kidx      = k_idx;
        s_rsp_ready = rsp_ready;
    endtask

    task automatic update_model();
        // poly8 responder reacts to what the DUT actually presented.
        if (comp_pending && s_kdone && !s_kstall) comp_pending = 1'b0;
        if (s_kstart && !s_kbusy) begin
            comp_pending = 1'b1;
            comp_res     = poly(s_kidx);
            comp_cnt     = (comp_lat < 0) ? $urandom_range(0, 4) : unsigned'(comp_lat);
            comp_calls++;
        end
        case (ref_stage)
            0: if (s_win >= 0) begin
                ref_grant = unsigned'(s_win);
                ref_idx   = rq_idx[s_win];
                ref_stage = 1;
                grant_log.push_back(unsigned'(s_win));
                if (!hold_req) rq_v[s_win] = 1'b0;
            end
            1: if (!s_kbusy) ref_stage = 2;
            2: if (s_kdone) ref_stage = 3;
            3: if (s_rsp_ready[ref_grant]) begin
                ref_stage = 0;
                ref_last  = ref_grant;
                ref_count = ref_count + 1'b1;
            end
            default: ref_stage = 0;
        endcase
        if (rand_req) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
                    rq_v[i]   = 1'b1;
                    rq_idx[i] = $urandom();
                end else if (rq_v[i] && $urandom_range(0, 7) == 0) begin
                    rq_v[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        drive_inputs();
        #1;
        check_and_sample();
        @(posedge clock);
        #1;
        update_model();
        cyc++;
    endtask

    task automatic run_calls(input int unsigned n, input int unsigned max_steps);
        logic [CNT_W-1:0] goal;
        int unsigned      k;
        goal = ref_count + CNT_W'(n);
        k    = 0;
        while (ref_count != goal && k < max_steps) begin
            step();
            k++;
        end
        check_eq("run_calls_in_budget", k < max_steps, 1'b1);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) rq_v[i] = 1'b0;
    endtask

    task automatic model_reset();
        ref_stage    = 0;
        ref_last     = NREQ - 1;
        ref_grant    = 0;
        ref_idx      = '0;
        ref_count    = '0;
        comp_pending = 1'b0;
        comp_cnt     = 0;
        comp_res     = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_idle"}, idle, 1'b1);
        check_eq({tag, "_k_start"}, k_start, 1'b0);
        check_eq({tag, "_k_stall"}, k_stall, 1'b1);
        check_eq({tag, "_k_idx"}, k_idx, '0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, '0);
        check_eq({tag, "_rsp_data"}, rsp_data, '0);
        check_eq({tag, "_calls_done"}, calls_done, '0);
        check_eq({tag, "_req_ready"}, req_ready, '0);
    endtask

    initial begin
        int unsigned k;
        logic [DATA_W-1:0] v;
        model_reset();
        clear_reqs();
        for (int i = 0; i < NREQ; i++) rq_idx[i] = '0;
        hold_req = 0; rand_req = 0; rand_busy = 0; rand_rsp = 0;
        busy_hold = 0; rsp_hold = 0; kstart_cycles = 0; cyc = 0; rsp_first = -1;
        comp_lat = 1; comp_calls = 0;
        drive_inputs();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        resetn = 1'b1;

        // All four requesting continuously from reset: 0,1,2,3,0.
        hold_req = 1;
        for (int i = 0; i < NREQ; i++) begin
            rq_v[i]   = 1'b1;
            rq_idx[i] = 32'd10 + 32'(i);
        end
        grant_log.delete();
        run_calls(5, 100);
        hold_req = 0;
        clear_reqs();
        check_eq("rr_order_len", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) check_eq("rr_order", grant_log[i], i % 4);

        // Single call, poly8 latency 4: rsp_valid 7 cycles after the accept cycle.
        rq_v[0] = 1'b1; rq_idx[0] = 32'd5; comp_lat = 4;
        cyc = 0; rsp_first = -1;
        run_calls(1, 40);
        check_eq("single_latency", rsp_first, 7);
        check_eq("single_calls_done", calls_done, 16'd6);

        // k_busy held 3 cycles during issue.
        rq_v[2] = 1'b1; rq_idx[2] = $urandom(); comp_lat = 2;
        busy_hold = 3; kstart_cycles = 0; k = comp_calls;
        run_calls(1, 40);
        check_eq("busy_kstart_cycles", kstart_cycles, 4);
        check_eq("busy_one_call", comp_calls - k, 1);

        // Response held off 5 cycles while another requester waits.
        rq_v[1] = 1'b1; rq_idx[1] = $urandom();
        rq_v[3] = 1'b1; rq_idx[3] = $urandom();
        rsp_hold = 5; comp_lat = 0;
        run_calls(2, 60);

        // Randomized traffic.
        rand_req = 1; rand_busy = 1; rand_rsp = 1; comp_lat = -1;
        repeat (400) step();
        rand_req = 0; rand_busy = 0; rand_rsp = 0; comp_lat = 1;
        clear_reqs();
        k = 0;
        while (ref_stage != 0 && k < 40) begin
            step();
            k++;
        end
        check_eq("drain_in_budget", k < 40, 1'b1);

        // Counter wrap from all-ones.
        force dut.calls_done_q = 16'hFFFF;
        #1;
        release dut.calls_done_q;
        ref_count = 16'hFFFF;
        rq_v[0] = 1'b1; rq_idx[0] = $urandom();
        run_calls(1, 40);
        check_eq("wrap_calls_done", calls_done, 16'h0000);

        // Reset while waiting for the result.
        rq_v[1] = 1'b1; rq_idx[1] = $urandom(); comp_lat = 4;
        k = 0;
        while (ref_stage != 2 && k < 20) begin
            step();
            k++;
        end
        check_eq("reach_wait", ref_stage, 2);
        step();
        resetn = 1'b0;
        clear_reqs();
        model_reset();
        drive_inputs();
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        v = $urandom();
        rq_v[0] = 1'b1; rq_idx[0] = v; comp_lat = 1;
        grant_log.delete();
        run_calls(1, 40);
        check_eq("post_rst_grant_len", grant_log.size(), 1);
        if (grant_log.size() > 0) check_eq("post_rst_grant", grant_log[0], 0);
        check_eq("post_rst_calls_done", calls_done, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
